stream_mux_rr: RTL

//   Parametrised N-channel, W-bit registered stream multiplexer; successor to the plain 2:1 datapath mux.

---
 rtl/stream_mux_rr.sv | 98 +++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or fixed-select arbitration
// feeding a single registered output stage (1-cycle latency, full throughput).
module stream_mux_rr #(
  parameter  int WIDTH = 32,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        fixed_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_ptr;

  logic [WIDTH-1:0] w_ch_data [N_CH];
  logic             w_load_en;
  logic             w_found;
  logic [N_CH-1:0]  w_grant;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_ptr_next;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_load_en = !r_out_valid || out_ready;

  // Candidates are visited in priority order; the first valid eligible one wins.
  // In fixed mode only the channel matching fixed_sel is eligible, so an
  // out-of-range select simply never matches.
  always_comb begin
    w_found   = 1'b0;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_sum     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (mode) begin
        w_sum = (SEL_W+1)'(k);
      end else begin
        w_sum = {1'b0, r_ptr} + (SEL_W+1)'(k);
        if (w_sum >= (SEL_W+1)'(N_CH)) begin
          w_sum = w_sum - (SEL_W+1)'(N_CH);
        end
      end
      w_idx = w_sum[SEL_W-1:0];
      if (!w_found && in_valid[w_idx] && (!mode || fixed_sel == w_idx)) begin
        w_found          = 1'b1;
        w_gnt_idx        = w_idx;
        w_grant[w_idx]   = 1'b1;
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == SEL_W'(N_CH-1)) ? '0 : w_gnt_idx + 1'b1;

  assign in_ready = (rst || !w_load_en) ? '0 : w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_found) begin
        r_out_data  <= w_ch_data[w_gnt_idx];
        r_out_ch    <= w_gnt_idx;
        r_out_valid <= 1'b1;
        if (!mode) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
